// File: rtl/pipe_pkg.sv
// Shared types for the five-stage dual-write-port pipeline control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int REG_AW = 3;

  // E-stage operand source select
  typedef enum logic [2:0] {
    FWD_RF   = 3'b000,  // register file read
    FWD_ALUM = 3'b001,  // port-A result in M
    FWD_RD1M = 3'b010,  // port-B write data in M
    FWD_RESW = 3'b011,  // port-A result in W
    FWD_RD1W = 3'b100   // port-B write data in W
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forward select for one E-stage source; the youngest matching writer wins.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: ra (E source address); wa3m/rwam, wa4m/rwbm (M port-A/B writes);
//        wa3w/rwaw, wa4w/rwbw (W port-A/B writes); sel (3-bit fwd_sel_t code).
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] wa3m,
  input  logic              rwam,
  input  logic [REG_AW-1:0] wa4m,
  input  logic              rwbm,
  input  logic [REG_AW-1:0] wa3w,
  input  logic              rwaw,
  input  logic [REG_AW-1:0] wa4w,
  input  logic              rwbw,
  output logic [2:0]        sel
);

  fwd_sel_t sel_e;

  // M beats W; within a stage port A beats port B. No hard-zero register.
  always_comb begin
    sel_e = FWD_RF;
    if (rwam && (wa3m == ra))      sel_e = FWD_ALUM;
    else if (rwbm && (wa4m == ra)) sel_e = FWD_RD1M;
    else if (rwaw && (wa3w == ra)) sel_e = FWD_RESW;
    else if (rwbw && (wa4w == ra)) sel_e = FWD_RD1W;
  end

  assign sel = sel_e;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hold/bubble/forward control plus memory-wait tracking (FSM, timeout, stall counter).
// Latency: stall/flush/forward outputs combinational (zero cycles); MemTimeout and StallCycles registered.
// Backpressure: a memory access without ack holds F/D/E/M and bubbles W until ack or abandon.
// Ports: clk, reset (sync, active-high); D/E/M/W register addresses and write flags;
//        BranchTakenE, MemReqM, MemAckM; StallF..StallM, FlushD/E/W, ForwardAE/BE,
//        MemTimeout (sticky), StallCycles (cycles with StallF=1, wraps).
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              RegWriteAE,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA4M,
  input  logic              RegWriteAM,
  input  logic              RegWriteBM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic [REG_AW-1:0] WA4W,
  input  logic              RegWriteAW,
  input  logic              RegWriteBW,
  input  logic              BranchTakenE,
  input  logic              MemReqM,
  input  logic              MemAckM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [2:0]        ForwardAE,
  output logic [2:0]        ForwardBE,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCycles
);

  fwd_sel u_fwd_a (
    .ra(RA1E), .wa3m(WA3M), .rwam(RegWriteAM), .wa4m(WA4M), .rwbm(RegWriteBM),
    .wa3w(WA3W), .rwaw(RegWriteAW), .wa4w(WA4W), .rwbw(RegWriteBW), .sel(ForwardAE)
  );

  fwd_sel u_fwd_b (
    .ra(RA2E), .wa3m(WA3M), .rwam(RegWriteAM), .wa4m(WA4M), .rwbm(RegWriteBM),
    .wa3w(WA3W), .rwaw(RegWriteAW), .wa4w(WA4W), .rwbw(RegWriteBW), .sel(ForwardBE)
  );

  logic lduse;
  logic memstall;

  assign lduse    = MemtoRegE && RegWriteAE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign memstall = MemReqM && !MemAckM;

  // Priority reset > memstall > branch > lduse. A memstall freezes E/D, so a
  // pending branch or load-use is simply re-evaluated once the ack arrives.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;  // W must not repeat the held M instruction's write
      end else if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lduse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_inc;
  logic        timeout_q;
  logic [CNT_W-1:0] stall_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (memstall) state_nxt = MEMWAIT;
      MEMWAIT: if (MemAckM || !MemReqM) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign wait_cnt_inc = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;

  // wait_cnt holds the number of wait cycles already spent on the current
  // access, so the timeout is visible from wait cycle MEM_TIMEOUT+1 onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= 4'd0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == RUN) wait_cnt <= 4'd0;
      else                  wait_cnt <= wait_cnt_inc;
      if (memstall && (32'(wait_cnt_inc) == MEM_TIMEOUT)) timeout_q <= 1'b1;
      if (StallF) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign MemTimeout  = timeout_q;
  assign StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a rule-level reference model.
// Latency/backpressure: n/a.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA4M, WA3W, WA4W;
  logic       RegWriteAE, MemtoRegE, RegWriteAM, RegWriteBM, RegWriteAW, RegWriteBW;
  logic       BranchTakenE, MemReqM, MemAckM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [2:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .RegWriteAE(RegWriteAE), .MemtoRegE(MemtoRegE),
    .WA3M(WA3M), .WA4M(WA4M), .RegWriteAM(RegWriteAM), .RegWriteBM(RegWriteBM),
    .WA3W(WA3W), .WA4W(WA4W), .RegWriteAW(RegWriteAW), .RegWriteBW(RegWriteBW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: consecutive wait cycles, sticky timeout, stall count.
  int m_run  = 0;
  bit m_tout = 1'b0;
  int m_cnt  = 0;

  // Operand source: scan writers youngest-first, first hit gives code 1..4.
  function automatic logic [2:0] ref_fwd(input logic [2:0] ra);
    logic [2:0] wa [4];
    logic       we [4];
    wa[0] = WA3M; we[0] = RegWriteAM;
    wa[1] = WA4M; we[1] = RegWriteBM;
    wa[2] = WA3W; we[2] = RegWriteAW;
    wa[3] = WA4W; we[3] = RegWriteBW;
    for (int i = 0; i < 4; i++)
      if (we[i] && wa[i] == ra) return 3'(i + 1);
    return 3'd0;
  endfunction

  // Compare all outputs against the model, advance the model, move to next negedge.
  task automatic cycle();
    bit ms, br, ld;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    ms = MemReqM && !MemAckM;
    br = BranchTakenE;
    ld = MemtoRegE && RegWriteAE && (WA3E == RA1D || WA3E == RA2D);
    e_sf = 0; e_sd = 0; e_se = 0; e_sm = 0; e_fd = 0; e_fe = 0; e_fw = 0;
    if (!reset) begin
      if (ms) begin
        e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fw = 1;
      end else if (br) begin
        e_fd = 1; e_fe = 1;
      end else if (ld) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
    end
    chk("m_StallF", StallF, e_sf);
    chk("m_StallD", StallD, e_sd);
    chk("m_StallE", StallE, e_se);
    chk("m_StallM", StallM, e_sm);
    chk("m_FlushD", FlushD, e_fd);
    chk("m_FlushE", FlushE, e_fe);
    chk("m_FlushW", FlushW, e_fw);
    chk("m_ForwardAE", ForwardAE, ref_fwd(RA1E));
    chk("m_ForwardBE", ForwardBE, ref_fwd(RA2E));
    chk("m_MemTimeout", MemTimeout, m_tout);
    chk("m_StallCycles", StallCycles, m_cnt);
    if (reset) begin
      m_run = 0; m_tout = 0; m_cnt = 0;
    end else begin
      m_run = ms ? m_run + 1 : 0;
      if (ms && m_run >= MEM_TIMEOUT) m_tout = 1;
      if (e_sf) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    reset = 0;
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA4M, WA3W, WA4W} = '0;
    {RegWriteAE, MemtoRegE, RegWriteAM, RegWriteBM, RegWriteAW, RegWriteBW} = '0;
    {BranchTakenE, MemReqM, MemAckM} = '0;
  endtask

  int cnt0;

  initial begin
    clear_in();
    reset = 1;
    @(negedge clk);
    #1;
    chk("rst_stallF_forced", StallF, 0);
    cycle();
    cycle();
    clear_in();
    #1;
    chk("rst_StallCycles", StallCycles, 0);
    chk("rst_MemTimeout", MemTimeout, 0);

    // Forwarding priority: M port A beats W port B, then W port B alone.
    RA1E = 3'd5; WA3M = 3'd5; RegWriteAM = 1; WA4W = 3'd5; RegWriteBW = 1;
    #1;
    chk("fwd_alum_first", ForwardAE, 3'b001);
    cycle();
    RegWriteAM = 0;
    #1;
    chk("fwd_rd1w", ForwardAE, 3'b100);
    cycle();
    RA2E = 3'd0; WA4M = 3'd0; RegWriteBM = 1; WA3W = 3'd0; RegWriteAW = 1;
    #1;
    chk("fwd_rd1m_r0", ForwardBE, 3'b010);
    cycle();
    clear_in();

    // Load-use: one bubble, one counted stall cycle.
    cnt0 = m_cnt;
    MemtoRegE = 1; RegWriteAE = 1; WA3E = 3'd2; RA2D = 3'd2; RA1D = 3'd7;
    #1;
    chk("ld_StallF", StallF, 1);
    chk("ld_FlushE", FlushE, 1);
    chk("ld_StallE", StallE, 0);
    cycle();
    clear_in();
    #1;
    chk("ld_release", StallF, 0);
    chk("ld_StallCycles", StallCycles, cnt0 + 1);
    cycle();

    // Same-cycle ack: no stall at all.
    MemReqM = 1; MemAckM = 1;
    #1;
    chk("ack0_no_stall", StallF, 0);
    cycle();
    clear_in();

    // Three-cycle memory wait.
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      MemReqM = 1; MemAckM = 0;
      #1;
      chk("mw_StallM", StallM, 1);
      chk("mw_FlushW", FlushW, 1);
      cycle();
    end
    MemAckM = 1;
    #1;
    chk("mw_ack_StallF", StallF, 0);
    cycle();
    clear_in();
    #1;
    chk("mw_StallCycles", StallCycles, cnt0 + 3);
    cycle();

    // Branch held by a memstall, taken on release.
    BranchTakenE = 1; MemtoRegE = 1; RegWriteAE = 1; WA3E = 3'd4; RA1D = 3'd4;
    for (int i = 0; i < 2; i++) begin
      MemReqM = 1; MemAckM = 0;
      #1;
      chk("br_ms_FlushD", FlushD, 0);
      chk("br_ms_FlushE", FlushE, 0);
      cycle();
    end
    MemAckM = 1;
    #1;
    chk("br_rel_FlushD", FlushD, 1);
    chk("br_rel_FlushE", FlushE, 1);
    chk("br_rel_no_ldstall", StallF, 0);
    cycle();
    clear_in();

    // Timeout after 15 wait cycles, sticky until reset.
    for (int i = 1; i <= 20; i++) begin
      MemReqM = 1;
      #1;
      chk($sformatf("to_cyc%0d", i), MemTimeout, (i >= 16) ? 1 : 0);
      cycle();
    end
    clear_in();
    #1;
    chk("to_sticky", MemTimeout, 1);
    cycle();
    reset = 1; MemReqM = 1;
    #1;
    chk("to_rst_StallF", StallF, 0);
    chk("to_rst_FlushW", FlushW, 0);
    cycle();
    clear_in();
    #1;
    chk("to_cleared", MemTimeout, 0);
    cycle();

    // Reset mid-wait must restart the wait count.
    for (int i = 0; i < 7; i++) begin
      MemReqM = 1;
      #1;
      cycle();
    end
    reset = 1;
    #1;
    chk("rmw_StallF", StallF, 0);
    cycle();
    clear_in();
    #1;
    chk("rmw_StallCycles", StallCycles, 0);
    chk("rmw_MemTimeout", MemTimeout, 0);
    chk("rmw_StallM", StallM, 0);
    cycle();
    for (int i = 0; i < 12; i++) begin
      MemReqM = 1;
      #1;
      chk("rmw_no_spurious", MemTimeout, 0);
      cycle();
    end
    clear_in();
    #1;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      RA1D         = 3'($urandom_range(0, 3));
      RA2D         = 3'($urandom_range(0, 3));
      RA1E         = 3'($urandom_range(0, 3));
      RA2E         = 3'($urandom_range(0, 3));
      WA3E         = 3'($urandom_range(0, 3));
      WA3M         = 3'($urandom_range(0, 3));
      WA4M         = 3'($urandom_range(0, 3));
      WA3W         = 3'($urandom_range(0, 3));
      WA4W         = 3'($urandom_range(0, 3));
      RegWriteAE   = 1'($urandom);
      MemtoRegE    = 1'($urandom);
      RegWriteAM   = 1'($urandom);
      RegWriteBM   = 1'($urandom);
      RegWriteAW   = 1'($urandom);
      RegWriteBW   = 1'($urandom);
      BranchTakenE = ($urandom_range(0, 3) == 0);
      MemReqM      = ($urandom_range(0, 9) < 4);
      MemAckM      = (m_run > 0 && n % 500 < 40) ? 1'b0 : ($urandom_range(0, 2) == 0);
      #1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
